// File: rtl/param_wt_cache.sv
// Set-associative write-through cache, one 32-bit word per line, no-write-allocate, RR replacement.
// Optional hit/miss counters when CACHE_STATS_EN is defined.
module param_wt_cache #(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_i,
  output logic        flush_busy_o,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_error_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
`ifdef CACHE_STATS_EN
  input  logic        stat_clr_i,
  output logic [31:0] stat_hits_o,
  output logic [31:0] stat_misses_o,
`endif
  input  logic        mem_error_i
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam int unsigned WAY_W = $clog2(WAYS);

  typedef enum logic [2:0] {StIdle, StLookup, StMemReq, StMemWait, StResp, StFlush} state_e;

  state_e            r_state;
  logic [29:0]       r_addr;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              r_hit;
  logic [WAY_W-1:0]  r_hit_way;
  logic              r_flush_pending;
  logic [IDX_W-1:0]  r_flush_cnt;

  logic [WAYS-1:0]   r_valid [SETS];
  logic [WAY_W-1:0]  r_rr    [SETS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [31:0]       r_data  [SETS][WAYS];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic [WAY_W-1:0]  w_victim;
  logic              w_all_valid;
  logic              w_gnt;
  logic              w_mem_done;
  logic              w_fill;
  logic              w_merge;
  logic              w_unused;

  assign w_idx    = r_addr[IDX_W-1:0];
  assign w_tag    = r_addr[29:IDX_W];
  assign w_unused = ^core_addr_i[1:0];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest invalid way wins; the RR pointer is only consulted when the set is full.
  always_comb begin
    w_all_valid = &r_valid[w_idx];
    w_victim    = r_rr[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
    end
  end

  assign w_gnt      = (r_state == StIdle) & core_req_i & ~r_flush_pending & ~flush_i;
  assign w_mem_done = (r_state == StMemWait) & mem_rvalid_i;
  assign w_fill     = w_mem_done & ~mem_error_i & ~r_we;
  assign w_merge    = w_mem_done & ~mem_error_i & r_we & r_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= StIdle;
      r_addr          <= '0;
      r_we            <= 1'b0;
      r_be            <= '0;
      r_wdata         <= '0;
      r_rdata         <= '0;
      r_err           <= 1'b0;
      r_hit           <= 1'b0;
      r_hit_way       <= '0;
      r_flush_pending <= 1'b0;
      r_flush_cnt     <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      if (flush_i && (r_state != StIdle) && (r_state != StFlush)) r_flush_pending <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (w_gnt) begin
            r_addr  <= core_addr_i[31:2];
            r_we    <= core_we_i;
            r_be    <= core_be_i;
            r_wdata <= core_wdata_i;
            r_state <= StLookup;
          end else if (r_flush_pending || flush_i) begin
            r_flush_pending <= 1'b0;
            r_flush_cnt     <= '0;
            r_state         <= StFlush;
          end
        end
        StLookup: begin
          r_hit     <= w_hit;
          r_hit_way <= w_hit_way;
          if (w_hit && !r_we) begin
            r_rdata <= r_data[w_idx][w_hit_way];
            r_err   <= 1'b0;
            r_state <= StResp;
          end else begin
            r_state <= StMemReq;
          end
        end
        StMemReq: begin
          if (mem_gnt_i) r_state <= StMemWait;
        end
        StMemWait: begin
          if (mem_rvalid_i) begin
            r_rdata <= mem_rdata_i;
            r_err   <= mem_error_i;
            r_state <= StResp;
            if (w_fill) begin
              r_valid[w_idx][w_victim] <= 1'b1;
              if (w_all_valid) r_rr[w_idx] <= r_rr[w_idx] + WAY_W'(1);
            end
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        StFlush: begin
          r_valid[r_flush_cnt] <= '0;
          r_flush_cnt          <= r_flush_cnt + IDX_W'(1);
          if (r_flush_cnt == IDX_W'(SETS - 1)) begin
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx][w_victim]  <= w_tag;
      r_data[w_idx][w_victim] <= mem_rdata_i;
    end
    if (w_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_data[w_idx][r_hit_way][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (stat_clr_i) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (r_state == StLookup) begin
      if (w_hit) begin
        if (r_hits != 32'hFFFF_FFFF) r_hits <= r_hits + 32'd1;
      end else begin
        if (r_misses != 32'hFFFF_FFFF) r_misses <= r_misses + 32'd1;
      end
    end
  end

  assign stat_hits_o   = r_hits;
  assign stat_misses_o = r_misses;
`endif

  assign core_gnt_o    = w_gnt;
  assign core_rvalid_o = (r_state == StResp);
  assign core_rdata_o  = core_rvalid_o ? r_rdata : '0;
  assign core_error_o  = core_rvalid_o & r_err;
  assign flush_busy_o  = r_flush_pending | (r_state == StFlush);

  assign mem_req_o   = (r_state == StMemReq);
  assign mem_addr_o  = mem_req_o ? {r_addr, 2'b00} : '0;
  assign mem_we_o    = mem_req_o & r_we;
  assign mem_be_o    = mem_req_o ? (r_we ? r_be : 4'hF) : '0;
  assign mem_wdata_o = mem_we_o ? r_wdata : '0;

endmodule
